// File: rtl/core_pkg.sv
// Shared core constants and the writeback request record used by pipeline writeback stages.
package core_pkg;
  localparam int XLEN      = 32;
  localparam int NREGS     = 32;
  localparam int REG_IDX_W = $clog2(NREGS);

  // 'reg' is a keyword, so the destination index field is named wreg.
  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] wreg;
    logic [XLEN-1:0]      data;
  } wb_req_t;
endpackage

// File: rtl/wb_scoreboard.sv
// Per-register busy vector: set on allocation, clear on accepted write, set wins on collision.
// Latency 1 (updates at the next edge); x0 is never busy.
module wb_scoreboard
  import core_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 set_i,
  input  logic [REG_IDX_W-1:0] set_idx_i,
  input  logic                 clr_i,
  input  logic [REG_IDX_W-1:0] clr_idx_i,
  output logic [NREGS-1:0]     busy_o
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // Clear first so a same-cycle allocation of the same register survives.
  always_comb begin
    busy_d = busy_q;
    if (clr_i) busy_d[clr_idx_i] = 1'b0;
    if (set_i) busy_d[set_idx_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port owner: arbitrates ALU (req0) vs load (req1) writeback with starvation guard.
// Commit latency 1; no buffering, back-pressure is carried entirely by the readies.
module regfile_wb_arbiter
  import core_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0_valid,
  input  logic [REG_IDX_W-1:0] req0_reg,
  input  logic [XLEN-1:0]      req0_data,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [REG_IDX_W-1:0] req1_reg,
  input  logic [XLEN-1:0]      req1_data,
  output logic                 req1_ready,
  input  logic                 alloc_valid,
  input  logic [REG_IDX_W-1:0] alloc_reg,
  output logic                 rf_we,
  output logic [REG_IDX_W-1:0] rf_wreg,
  output logic [XLEN-1:0]      rf_wdata,
  output logic [NREGS-1:0]     busy,
  output logic                 starve_force
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 rf_we_q, rf_we_d;
  logic [REG_IDX_W-1:0] rf_wreg_q;
  logic [XLEN-1:0]      rf_wdata_q;
  logic                 acc0, acc1;
  wb_req_t              win;

  assign starve_force = (cnt_q == CNT_W'(STARVE_LIMIT));
  assign req0_ready   = reset && !(starve_force && req1_valid);
  assign req1_ready   = reset && (!req0_valid || starve_force);
  assign acc0         = req0_valid && req0_ready;
  assign acc1         = req1_valid && req1_ready;

  always_comb begin
    win = '0;
    if (acc0) begin
      win.valid = 1'b1;
      win.wreg  = req0_reg;
      win.data  = req0_data;
    end else if (acc1) begin
      win.valid = 1'b1;
      win.wreg  = req1_reg;
      win.data  = req1_data;
    end
  end

  // Writes to x0 complete the handshake but never reach the register file.
  assign rf_we_d = win.valid && (win.wreg != '0);

  always_comb begin
    cnt_d = cnt_q;
    if (!req1_valid || acc1)                cnt_d = '0;
    else if (cnt_q != CNT_W'(STARVE_LIMIT)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rf_we_q    <= 1'b0;
      rf_wreg_q  <= '0;
      rf_wdata_q <= '0;
      cnt_q      <= '0;
    end else begin
      rf_we_q <= rf_we_d;
      cnt_q   <= cnt_d;
      if (win.valid) begin
        rf_wreg_q  <= win.wreg;
        rf_wdata_q <= win.data;
      end
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_wreg  = rf_wreg_q;
  assign rf_wdata = rf_wdata_q;

  wb_scoreboard u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .set_i     (alloc_valid && (alloc_reg != '0)),
    .set_idx_i (alloc_reg),
    .clr_i     (win.valid),
    .clr_idx_i (win.wreg),
    .busy_o    (busy)
  );

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Sole owner of the register file's single write port. Arbitrates between two writeback requesters: req0 = ALU writeback, req1 = load/multicycle writeback.
- Uses valid/ready handshakes and drives a registered write (rf_we/rf_wreg/rf_wdata) into the register file.
- Keeps a per-register busy scoreboard. Issue sets a bit at allocation; the bit clears when that register's write is accepted. Decode uses the scoreboard for hazard stalls.

Parameters:
- XLEN, 32, data width of write data.
- NREGS, 32, number of architectural registers; index width is log2(NREGS).
- STARVE_LIMIT, 4, consecutive cycles req1 may be refused before it is forced to win.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- req0_valid  in  1  ALU writeback request.
- req0_reg  in  5  destination register.
- req0_data  in  XLEN  write data.
- req0_ready  out  1  req0 accepted this cycle when high with req0_valid.
- req1_valid  in  1  load/multicycle writeback request.
- req1_reg  in  5  destination register.
- req1_data  in  XLEN  write data.
- req1_ready  out  1  req1 accepted this cycle when high with req1_valid.
- alloc_valid  in  1  issue allocates a destination register.
- alloc_reg  in  5  register being allocated.
- rf_we  out  1  register file write enable (registered).
- rf_wreg  out  5  register file write index (registered).
- rf_wdata  out  XLEN  register file write data (registered).
- busy  out  NREGS  scoreboard; bit r high = write to r pending.
- starve_force  out  1  high when req1 holds forced priority (debug/perf).

Behaviour:
- **Reset** (reset==0 at posedge):
  - rf_we=0, rf_wreg=0, rf_wdata=0, busy=0, starvation counter=0, starve_force=0.
  - Readies are 0 while reset is low.
  - Reset mid-operation drops any accepted-but-uncommitted write and clears all busy bits.
- **Arbitration** (combinational, at most one grant per cycle):
  - Default is fixed priority req0 > req1.
  - starve_force = (cnt == STARVE_LIMIT).
  - req0_ready = !(starve_force && req1_valid).
  - req1_ready = !req0_valid || starve_force.
  - Readies do not depend on their own valid; a requester holds valid, reg and data stable until accepted.
- **Starvation counter**:
  - Increments, saturating at STARVE_LIMIT, on cycles with req1_valid && !req1_ready.
  - Clears on req1 acceptance or when req1_valid is low.
  - With STARVE_LIMIT=4, req1 waits at most 4 cycles and wins on the 5th.
- **Commit**, on the posedge after acceptance (latency 1):
  - rf_wreg/rf_wdata take the winner's reg/data.
  - rf_we=1 unless the winner's reg==0. Writes to x0 are accepted (ready handshake completes) but rf_we stays 0.
  - With no acceptance, rf_we=0 and rf_wreg/rf_wdata hold their previous values.
- **Scoreboard**:
  - On acceptance of a write to r (r!=0), busy[r] clears at the same edge at which rf_we rises.
  - On alloc_valid with alloc_reg!=0, busy[alloc_reg] sets at the next edge.
  - Allocation and acceptance of the same register in the same cycle: set wins, so busy stays 1 because the newer producer is pending.
  - busy[0] is constantly 0; alloc of x0 is ignored.
  - Writes to non-busy registers are legal and leave busy unchanged.
- No buffering inside the block; back-pressure is carried entirely by ready.

Decomposition:
- **Shared package** (core_pkg), holding:
  - XLEN, NREGS and the REG_IDX_W constants.
  - A wb_req_t struct {valid, reg, data}, reused by the pipeline writeback stages.
- **Sub-module** wb_scoreboard: busy vector with set/clear ports and the set-wins rule.
- Arbitration, the starvation counter and the output register stay in the top module.

Test Plan:
- **Reset**: hold reset=0 for 3 cycles with both valids high, then release. During reset, rf_we=0, busy=0 and both readies are 0. First cycle after release, req0 is granted.
- **Single write**: alloc x5, next cycle req0 writes x5 with 0x0000_001E.
  - busy[5]=1 one cycle after alloc.
  - The cycle after acceptance: rf_we=1, rf_wreg=5, rf_wdata=0x1E, busy[5]=0.
- **Contention**: req0 and req1 both valid every cycle, writing x2 and x3 respectively.
  - req0 wins 4 cycles while req1_ready=0.
  - 5th cycle: starve_force=1, req1 accepted, rf_wreg=3 one cycle later.
  - Counter returns to 0 and req0 resumes.
- **x0 drop**: req1 writes x0 with 0xDEADBEEF. req1_ready=1 and the handshake completes; rf_we stays 0 and busy is unchanged.
- **Set-wins**: busy[6]=1; alloc x6 in the same cycle req0's write to x6 is accepted. rf_we=1 to x6 next cycle, and busy[6] remains 1.
- **Reset mid-flight**: accept a req0 write to x7 (busy[7]=1 from a prior alloc), then assert reset in the following cycle. After the edge, rf_we=0 and busy=0.
